gemm_loop_sched: RTL and testbench
==================================

Name: gemm_loop_sched

Overview:
Instruction-level sequencer for the 5-stage GEMM datapath (UOP/IDX/MEM/EX/WB). It accepts one 128-bit GEMM instruction via a valid/ready handshake and runs the two-level loop nest (iter_out × iter_in × uop range). Each issue cycle it drives the micro-op address and the loop offsets into the UOP stage. After the last issue it waits for the pipeline to drain, then pulses done so the core can pop the next instruction.

Parameters:
INS_WIDTH, 128, instruction width
UPC_WIDTH, 13, micro-op address width
ITER_WIDTH, 14, loop-extent field width
ACC_OFF_WIDTH, 11, dst offset width (ACC_IDX_WIDTH-1)
INP_OFF_WIDTH, 11, src offset width (INP_IDX_WIDTH-1)
WGT_OFF_WIDTH, 10, wgt offset width (WGT_IDX_WIDTH-1)
PIPE_DEPTH, 4, cycles from issue to WB write

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
insn  in  INS_WIDTH  instruction
insn_valid  in  1  instruction offered
insn_ready  out  1  scheduler can accept
stall  in  1  hold issue, e.g. for a memory conflict
issue_valid  out  1  issue slot carries a valid uop
upc  out  UPC_WIDTH  micro-op address
dst_offset_out / dst_offset_in  out  ACC_OFF_WIDTH  dst loop offsets
src_offset_out / src_offset_in  out  INP_OFF_WIDTH  src loop offsets
wgt_offset_out / wgt_offset_in  out  WGT_OFF_WIDTH  wgt loop offsets
reg_reset  out  1  latched insn reset bit; accumulator-zero mode
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Insn fields:
  - opcode[2:0] (GEMM = 3'b010)
  - reset[7]
  - uop_bgn[20:8]
  - uop_end[34:21]
  - iter_out[48:35]
  - iter_in[62:49]
  - dst_fo[73:63], dst_fi[84:74]
  - src_fo[95:85], src_fi[106:96]
  - wgt_fo[116:107], wgt_fi[126:117]
- Reset state: IDLE.
  - All outputs 0 except insn_ready=1.
  - Counters and latched fields cleared.
  - Reset mid-operation aborts the loop immediately; no done pulse is generated.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - insn_ready=1.
  - On insn_valid: latch all fields; clear cnt_out, cnt_in and all offsets; set upc=uop_bgn.
  - Next state:
    - opcode != GEMM: DONE.
    - GEMM with zero work (iter_out==0, iter_in==0, or uop_end<=uop_bgn): DONE. issue_valid is never asserted.
    - Otherwise: ISSUE.
- insn_ready is 0 in all states other than IDLE; insn is ignored there.
- ISSUE:
  - issue_valid = !stall. While stall=1, all counters and outputs hold.
  - Per unstalled cycle, evaluated in priority order:
    - If upc != uop_end-1: upc++.
    - Else upc=uop_bgn, and:
      - If cnt_in != iter_in-1: cnt_in++; all *_offset_in += *_fi.
      - Else cnt_in=0; all *_offset_in=0; and:
        - If cnt_out != iter_out-1: cnt_out++; all *_offset_out += *_fo.
        - Else (final issue): go to DRAIN.
  - Offsets are built by accumulation, not multiplication. Each wraps modulo 2^width.
  - Output values therefore equal cnt×factor mod 2^width.
- Total issue_valid cycles = iter_out × iter_in × (uop_end − uop_bgn).
- DRAIN:
  - Drain counter counts PIPE_DEPTH cycles.
  - issue_valid=0; stall is ignored.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - busy deasserts in the same cycle insn_ready reasserts.
- Latency:
  - GEMM: done rises N + PIPE_DEPTH + 1 cycles after the accept edge (N = issue count, excluding stalls).
  - Non-GEMM or zero-work: done rises 1 cycle after the accept edge.
- reg_reset:
  - Held constant from accept until return to IDLE.
  - Cleared to 0 in IDLE.
- upc wrap:
  - uop_end is 14 bits. uop_end = 2^13 is legal, giving last upc = 8191.
  - The comparison is done at 14 bits.

Test Plan:
1. GEMM with uop_bgn=5, uop_end=8, iter_out=1, iter_in=1 -> 3 issue cycles with upc=5,6,7 and offsets 0; done exactly 8 cycles after accept.
2. uop_bgn=0, uop_end=2, iter_out=2, iter_in=3, dst_fo=16, dst_fi=1, src_fi=4, wgt_fo=2 -> 12 issues:
   - dst_offset_in sequence: 0,0,1,1,2,2 per outer iteration.
   - dst_offset_out = 0 for the first 6 issues, then 16.
   - src_offset_in sequence: 0,0,4,4,8,8 per outer iteration.
   - wgt_offset_out = 2 for the last 6 issues.
3. GEMM with iter_in=0, and separately opcode=3'b000 -> no issue_valid; done 1 cycle after accept; insn_ready back to 1 on the next cycle.
4. Same setup as test 2, with stall held high for 3 cycles during the 4th issue -> sequence identical, issue count 12, done delayed by exactly 3 cycles.
5. Offset wrap: wgt_fi=1000, iter_in=3, single uop -> wgt_offset_in = 0, 1000, 976 (2000 mod 1024).
6. Drive rst low during ISSUE -> all outputs return to reset values asynchronously, no done pulse; a new instruction is accepted normally after rst goes high.

Source files
------------

// File: rtl/gemm_loop_sched.sv
// GEMM instruction sequencer: walks the iter_out x iter_in x uop loop nest, drives
// micro-op addresses and accumulated loop offsets, then drains the pipe and pulses done.
module gemm_loop_sched #(
  parameter int INS_WIDTH     = 128,
  parameter int UPC_WIDTH     = 13,
  parameter int ITER_WIDTH    = 14,
  parameter int ACC_OFF_WIDTH = 11,
  parameter int INP_OFF_WIDTH = 11,
  parameter int WGT_OFF_WIDTH = 10,
  parameter int PIPE_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INS_WIDTH-1:0]     insn,
  input  logic                     insn_valid,
  output logic                     insn_ready,
  input  logic                     stall,
  output logic                     issue_valid,
  output logic [UPC_WIDTH-1:0]     upc,
  output logic [ACC_OFF_WIDTH-1:0] dst_offset_out,
  output logic [ACC_OFF_WIDTH-1:0] dst_offset_in,
  output logic [INP_OFF_WIDTH-1:0] src_offset_out,
  output logic [INP_OFF_WIDTH-1:0] src_offset_in,
  output logic [WGT_OFF_WIDTH-1:0] wgt_offset_out,
  output logic [WGT_OFF_WIDTH-1:0] wgt_offset_in,
  output logic                     reg_reset,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  // Handshake: an instruction is taken on a clock edge where insn_valid && insn_ready;
  // insn_ready is high only in IDLE, and insn is not looked at in any other state.

  localparam logic [2:0] OP_GEMM = 3'b010;

  localparam int UOP_BGN_LSB  = 8;
  localparam int UOP_END_LSB  = UOP_BGN_LSB + UPC_WIDTH;
  localparam int ITER_OUT_LSB = UOP_END_LSB + UPC_WIDTH + 1;
  localparam int ITER_IN_LSB  = ITER_OUT_LSB + ITER_WIDTH;
  localparam int DST_FO_LSB   = ITER_IN_LSB + ITER_WIDTH;
  localparam int DST_FI_LSB   = DST_FO_LSB + ACC_OFF_WIDTH;
  localparam int SRC_FO_LSB   = DST_FI_LSB + ACC_OFF_WIDTH;
  localparam int SRC_FI_LSB   = SRC_FO_LSB + INP_OFF_WIDTH;
  localparam int WGT_FO_LSB   = SRC_FI_LSB + INP_OFF_WIDTH;
  localparam int WGT_FI_LSB   = WGT_FO_LSB + WGT_OFF_WIDTH;
  localparam int INS_USED_MSB = WGT_FI_LSB + WGT_OFF_WIDTH - 1;

  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DW-1:0]         DRAIN_LAST = DW'(PIPE_DEPTH - 1);
  localparam logic [UPC_WIDTH-1:0]  UPC_ONE    = UPC_WIDTH'(1);
  localparam logic [UPC_WIDTH:0]    END_ONE    = (UPC_WIDTH + 1)'(1);
  localparam logic [ITER_WIDTH-1:0] ITER_ONE   = ITER_WIDTH'(1);
  localparam logic [DW-1:0]         DRAIN_ONE  = DW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Instruction field decode
  logic [2:0]               f_opcode;
  logic                     f_reset;
  logic [UPC_WIDTH-1:0]     f_uop_bgn;
  logic [UPC_WIDTH:0]       f_uop_end;
  logic [ITER_WIDTH-1:0]    f_iter_out, f_iter_in;
  logic                     unused_insn_bits;

  assign f_opcode   = insn[2:0];
  assign f_reset    = insn[7];
  assign f_uop_bgn  = insn[UOP_BGN_LSB +: UPC_WIDTH];
  assign f_uop_end  = insn[UOP_END_LSB +: UPC_WIDTH + 1];
  assign f_iter_out = insn[ITER_OUT_LSB +: ITER_WIDTH];
  assign f_iter_in  = insn[ITER_IN_LSB +: ITER_WIDTH];
  assign unused_insn_bits = ^{insn[6:3], insn[INS_WIDTH-1:INS_USED_MSB]};

  // Latched loop description
  logic [UPC_WIDTH-1:0]     l_uop_bgn;
  logic [UPC_WIDTH:0]       l_uop_end;
  logic [ITER_WIDTH-1:0]    l_iter_out, l_iter_in;
  logic [ACC_OFF_WIDTH-1:0] l_dst_fo, l_dst_fi;
  logic [INP_OFF_WIDTH-1:0] l_src_fo, l_src_fi;
  logic [WGT_OFF_WIDTH-1:0] l_wgt_fo, l_wgt_fi;

  logic [ITER_WIDTH-1:0]    cnt_out, cnt_in;
  logic [DW-1:0]            drain_cnt;

  logic accept, is_gemm, zero_work, adv;
  logic upc_last, in_last, out_last, final_issue, drain_done;

  assign accept    = (state == S_IDLE) && insn_valid;
  assign is_gemm   = (f_opcode == OP_GEMM);
  assign zero_work = (f_iter_out == '0) || (f_iter_in == '0) ||
                     (f_uop_end <= {1'b0, f_uop_bgn});
  assign adv       = (state == S_ISSUE) && !stall;

  // Compared at full uop_end width so uop_end = 2^UPC_WIDTH ends at the top address.
  assign upc_last    = ({1'b0, upc} == (l_uop_end - END_ONE));
  assign in_last     = (cnt_in  == (l_iter_in  - ITER_ONE));
  assign out_last    = (cnt_out == (l_iter_out - ITER_ONE));
  assign final_issue = adv && upc_last && in_last && out_last;
  assign drain_done  = (drain_cnt == DRAIN_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    insn_ready  = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    issue_valid = 1'b0;
    case (state)
      S_IDLE: begin
        insn_ready = 1'b1;
        busy       = 1'b0;
        if (insn_valid) state_next = (is_gemm && !zero_work) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        issue_valid = !stall;
        if (final_issue) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_uop_bgn      <= '0;
      l_uop_end      <= '0;
      l_iter_out     <= '0;
      l_iter_in      <= '0;
      l_dst_fo       <= '0;
      l_dst_fi       <= '0;
      l_src_fo       <= '0;
      l_src_fi       <= '0;
      l_wgt_fo       <= '0;
      l_wgt_fi       <= '0;
      cnt_out        <= '0;
      cnt_in         <= '0;
      upc            <= '0;
      dst_offset_out <= '0;
      dst_offset_in  <= '0;
      src_offset_out <= '0;
      src_offset_in  <= '0;
      wgt_offset_out <= '0;
      wgt_offset_in  <= '0;
      reg_reset      <= 1'b0;
      drain_cnt      <= '0;
    end else begin
      if (accept) begin
        l_uop_bgn      <= f_uop_bgn;
        l_uop_end      <= f_uop_end;
        l_iter_out     <= f_iter_out;
        l_iter_in      <= f_iter_in;
        l_dst_fo       <= insn[DST_FO_LSB +: ACC_OFF_WIDTH];
        l_dst_fi       <= insn[DST_FI_LSB +: ACC_OFF_WIDTH];
        l_src_fo       <= insn[SRC_FO_LSB +: INP_OFF_WIDTH];
        l_src_fi       <= insn[SRC_FI_LSB +: INP_OFF_WIDTH];
        l_wgt_fo       <= insn[WGT_FO_LSB +: WGT_OFF_WIDTH];
        l_wgt_fi       <= insn[WGT_FI_LSB +: WGT_OFF_WIDTH];
        cnt_out        <= '0;
        cnt_in         <= '0;
        upc            <= f_uop_bgn;
        dst_offset_out <= '0;
        dst_offset_in  <= '0;
        src_offset_out <= '0;
        src_offset_in  <= '0;
        wgt_offset_out <= '0;
        wgt_offset_in  <= '0;
        reg_reset      <= f_reset;
      end else if (adv) begin
        // Offsets accumulate one factor per step and wrap at their own width.
        if (!upc_last) begin
          upc <= upc + UPC_ONE;
        end else begin
          upc <= l_uop_bgn;
          if (!in_last) begin
            cnt_in        <= cnt_in + ITER_ONE;
            dst_offset_in <= dst_offset_in + l_dst_fi;
            src_offset_in <= src_offset_in + l_src_fi;
            wgt_offset_in <= wgt_offset_in + l_wgt_fi;
          end else begin
            cnt_in        <= '0;
            dst_offset_in <= '0;
            src_offset_in <= '0;
            wgt_offset_in <= '0;
            if (!out_last) begin
              cnt_out        <= cnt_out + ITER_ONE;
              dst_offset_out <= dst_offset_out + l_dst_fo;
              src_offset_out <= src_offset_out + l_src_fo;
              wgt_offset_out <= wgt_offset_out + l_wgt_fo;
            end
          end
        end
      end

      if (state == S_DONE) reg_reset <= 1'b0;

      if (state == S_DRAIN) drain_cnt <= drain_cnt + DRAIN_ONE;
      else                  drain_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_gemm_loop_sched.sv
// Bench for gemm_loop_sched: directed and random GEMM instructions checked against a
// loop-nest reference model (expected issue stream plus done latency).
module tb_gemm_loop_sched;

  localparam int PIPE_DEPTH = 4;
  localparam int W = 77;

  logic         clk;
  logic         rst;
  logic [127:0] insn;
  logic         insn_valid;
  logic         insn_ready;
  logic         stall;
  logic         issue_valid;
  logic [12:0]  upc;
  logic [10:0]  dst_offset_out, dst_offset_in;
  logic [10:0]  src_offset_out, src_offset_in;
  logic [9:0]   wgt_offset_out, wgt_offset_in;
  logic         reg_reset;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  gemm_loop_sched #(.PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clk(clk), .rst(rst), .insn(insn), .insn_valid(insn_valid), .insn_ready(insn_ready),
    .stall(stall), .issue_valid(issue_valid), .upc(upc),
    .dst_offset_out(dst_offset_out), .dst_offset_in(dst_offset_in),
    .src_offset_out(src_offset_out), .src_offset_in(src_offset_in),
    .wgt_offset_out(wgt_offset_out), .wgt_offset_in(wgt_offset_in),
    .reg_reset(reg_reset), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  int  exp_n;
  logic exp_rr;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] make_insn(
    input logic [2:0] op, input logic rs, input logic [12:0] bgn, input logic [13:0] uend,
    input logic [13:0] io, input logic [13:0] ii,
    input logic [10:0] dfo, input logic [10:0] dfi, input logic [10:0] sfo, input logic [10:0] sfi,
    input logic [9:0] wfo, input logic [9:0] wfi);
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[2:0] = op;      v[7] = rs;
    v[20:8] = bgn;    v[34:21] = uend;
    v[48:35] = io;    v[62:49] = ii;
    v[73:63] = dfo;   v[84:74] = dfi;
    v[95:85] = sfo;   v[106:96] = sfi;
    v[116:107] = wfo; v[126:117] = wfi;
    return v;
  endfunction

  // Reference model: enumerate the loop nest directly; offset = count * factor mod 2^width.
  task automatic build_exp(input logic [127:0] ins);
    int op, bgn, uend, io, ii, dfo, dfi, sfo, sfi, wfo, wfi;
    logic [W-1:0] rec;
    op = int'(ins[2:0]);      bgn = int'(ins[20:8]);   uend = int'(ins[34:21]);
    io = int'(ins[48:35]);    ii = int'(ins[62:49]);
    dfo = int'(ins[73:63]);   dfi = int'(ins[84:74]);
    sfo = int'(ins[95:85]);   sfi = int'(ins[106:96]);
    wfo = int'(ins[116:107]); wfi = int'(ins[126:117]);
    exp_rr = ins[7];
    exp_q.delete();
    if (op == 2 && io > 0 && ii > 0 && uend > bgn) begin
      for (int o = 0; o < io; o++)
        for (int i = 0; i < ii; i++)
          for (int u = bgn; u < uend; u++) begin
            rec = {13'(u), 11'((o * dfo) % 2048), 11'((i * dfi) % 2048),
                   11'((o * sfo) % 2048), 11'((i * sfi) % 2048),
                   10'((o * wfo) % 1024), 10'((i * wfi) % 1024)};
            exp_q.push_back(rec);
          end
    end
    exp_n = exp_q.size();
  endtask

  // Driver + scoreboard for one instruction. stall_mode: 0 none, 1 hold 3 cycles
  // while issue number stall_at is pending, 2 random.
  task automatic run_insn(input logic [127:0] ins, input int stall_mode, input int stall_at);
    int cyc, issued, stall_cnt, hold, exp_lat;
    logic done_seen, st;
    logic [W-1:0] got, e;
    build_exp(ins);
    @(negedge clk);
    chk("ready_idle", insn_ready, 1'b1);
    insn = ins; insn_valid = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    cyc = 1; issued = 0; stall_cnt = 0; hold = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      if (stall_mode == 1)      st = (issued == stall_at) && (hold < 3);
      else if (stall_mode == 2) st = ($urandom_range(0, 3) == 0);
      else                      st = 1'b0;
      if (st) hold++;
      stall = st;
      insn_valid = 1'($urandom_range(0, 1));
      insn = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (st && issued < exp_n) stall_cnt++;
      chk("no_issue_in_stall", issue_valid & st, 1'b0);
      if (issue_valid) begin
        got = {upc, dst_offset_out, dst_offset_in, src_offset_out, src_offset_in,
               wgt_offset_out, wgt_offset_in};
        if (exp_q.size() == 0) chk("extra_issue", got, '0);
        else begin
          e = exp_q.pop_front();
          chk("issue", got, e);
        end
        issued++;
      end
      chk("busy", busy, 1'b1);
      chk("not_ready", insn_ready, 1'b0);
      chk("reg_reset", reg_reset, exp_rr);
      if (done) begin
        done_seen = 1'b1;
        exp_lat = (exp_n == 0) ? 1 : exp_n + stall_cnt + PIPE_DEPTH + 1;
        chk("done_latency", cyc, exp_lat);
      end
      @(posedge clk); #1;
      cyc++;
    end
    stall = 1'b0; insn_valid = 1'b0;
    chk("done_seen", done_seen, 1'b1);
    chk("issue_count", issued, exp_n);
    chk("done_one_cycle", done, 1'b0);
    chk("ready_back", insn_ready, 1'b1);
    chk("busy_clear", busy, 1'b0);
    chk("reg_reset_clear", reg_reset, 1'b0);
  endtask

  initial begin
    logic [127:0] t2;
    rst = 1'b0; insn = '0; insn_valid = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", insn_ready, 1'b1);
    chk("rst_issue", issue_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_outs", {upc, dst_offset_out, dst_offset_in, src_offset_out, src_offset_in,
                     wgt_offset_out, wgt_offset_in, reg_reset}, '0);
    @(negedge clk); rst = 1'b1;

    // Simple range, two-level nest, zero-work and non-GEMM, stall, wrap, top address
    run_insn(make_insn(3'b010, 1'b1, 13'd5, 14'd8, 14'd1, 14'd1, 11'd7, 11'd9, 11'd3, 11'd5, 10'd1, 10'd2), 0, 0);
    t2 = make_insn(3'b010, 1'b0, 13'd0, 14'd2, 14'd2, 14'd3, 11'd16, 11'd1, 11'd0, 11'd4, 10'd2, 10'd0);
    run_insn(t2, 0, 0);
    run_insn(make_insn(3'b010, 1'b1, 13'd0, 14'd4, 14'd2, 14'd0, 11'd1, 11'd1, 11'd1, 11'd1, 10'd1, 10'd1), 0, 0);
    run_insn(make_insn(3'b000, 1'b1, 13'd0, 14'd4, 14'd2, 14'd2, 11'd1, 11'd1, 11'd1, 11'd1, 10'd1, 10'd1), 0, 0);
    run_insn(make_insn(3'b010, 1'b0, 13'd9, 14'd9, 14'd2, 14'd2, 11'd1, 11'd1, 11'd1, 11'd1, 10'd1, 10'd1), 0, 0);
    run_insn(t2, 1, 3);
    run_insn(make_insn(3'b010, 1'b0, 13'd100, 14'd101, 14'd1, 14'd3, 11'd0, 11'd0, 11'd0, 11'd0, 10'd0, 10'd1000), 0, 0);
    run_insn(make_insn(3'b010, 1'b1, 13'd8190, 14'd8192, 14'd2, 14'd2, 11'd2000, 11'd1500, 11'd3, 11'd9, 10'd700, 10'd600), 0, 0);

    // Asynchronous reset in the middle of the loop
    build_exp(make_insn(3'b010, 1'b1, 13'd0, 14'd4, 14'd3, 14'd3, 11'd5, 11'd6, 11'd7, 11'd8, 10'd9, 10'd10));
    @(negedge clk);
    insn = make_insn(3'b010, 1'b1, 13'd0, 14'd4, 14'd3, 14'd3, 11'd5, 11'd6, 11'd7, 11'd8, 10'd9, 10'd10);
    insn_valid = 1'b1;
    @(posedge clk); #1; insn_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2; rst = 1'b0; #1;
    chk("abort_issue", issue_valid, 1'b0);
    chk("abort_ready", insn_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_outs", {upc, dst_offset_out, dst_offset_in, src_offset_out, src_offset_in,
                       wgt_offset_out, wgt_offset_in, reg_reset, done}, '0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 1'b0);
    end
    @(negedge clk); rst = 1'b1;
    exp_q.delete();
    run_insn(make_insn(3'b010, 1'b0, 13'd3, 14'd6, 14'd2, 14'd2, 11'd10, 11'd20, 11'd30, 11'd40, 10'd50, 10'd60), 0, 0);

    // Randomised instructions with random stalls and garbage offered while busy
    for (int k = 0; k < 20; k++) begin
      logic [2:0] op;
      logic [12:0] bgn;
      int rng;
      op  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      bgn = 13'($urandom_range(0, 8191));
      rng = $urandom_range(0, 4);
      if (int'(bgn) + rng > 8192) rng = 8192 - int'(bgn);
      run_insn(make_insn(op, 1'($urandom), bgn, 14'(int'(bgn) + rng),
                         14'($urandom_range(0, 3)), 14'($urandom_range(0, 3)),
                         11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom),
                         10'($urandom), 10'($urandom)), 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
